// File: rtl/call_latch.sv
// call_latch: request-registration stage ahead of the elevator Movement
// controller. It synchronises and edge-detects the car and hall buttons,
// holds each request until the door has dwelt open at that floor, and
// derives above/below/here hints from the current location.
module call_latch #(
    parameter int unsigned CLEAR_HOLD = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:1] inCall,
    input  logic [3:1] outCall,
    input  logic [3:1] loc,
    input  logic [3:1] door,
    output logic [3:1] inPend,
    output logic [3:1] outPend,
    output logic [3:1] pending,
    output logic       reqAbove,
    output logic       reqBelow,
    output logic       reqHere,
    output logic [3:1] served
);

    localparam logic [3:0] HOLD    = 4'(CLEAR_HOLD);
    localparam logic [3:0] HOLD_M1 = 4'(CLEAR_HOLD - 1);

    function automatic logic onehot3(input logic [2:0] v);
        return (v != 3'b000) && ((v & (v - 3'd1)) == 3'b000);
    endfunction

    // Button vector: [5:3] hall, [2:0] car.
    logic [5:0] btn;
    logic [5:0] s1_q, s2_q, prev_q;
    logic [5:0] rise;
    logic [3:1] in_rise, out_rise;

    logic [3:1] in_pend_q, in_pend_d;
    logic [3:1] out_pend_q, out_pend_d;
    logic [3:1] served_q;
    logic [3:1] floor_q, floor_d;
    logic [3:0] dwell_q, dwell_d;
    logic [3:1] svc;
    logic [3:1] clr;
    logic       loc_ok;
    logic       svc_any;

    assign btn      = {outCall, inCall};
    assign rise     = s2_q & ~prev_q;
    assign in_rise  = rise[2:0];
    assign out_rise = rise[5:3];

    assign svc     = door & loc;
    assign loc_ok  = onehot3(loc);
    assign svc_any = loc_ok && onehot3(svc);

    // Two-flop synchroniser plus history flop for edge detection.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
        end else begin
            s1_q   <= btn;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    // Dwell counting: a new service floor restarts the count at 1, so the
    // clear lands CLEAR_HOLD-1 edges after the first edge that sees service.
    always_comb begin
        logic [3:0] base;
        dwell_d = '0;
        floor_d = '0;
        clr     = '0;
        base    = '0;
        if (svc_any) begin
            floor_d = svc;
            base    = (svc == floor_q) ? dwell_q : 4'd0;
            if (base < HOLD) begin
                dwell_d = base + 4'd1;
                if (base == HOLD_M1) begin
                    clr = svc;
                end
            end else begin
                dwell_d = base;
            end
        end
    end

    // Request latches: set on an unsuppressed rise, clear wins over set.
    always_comb begin
        in_pend_d  = (in_pend_q  | (in_rise  & ~svc)) & ~clr;
        out_pend_d = (out_pend_q | (out_rise & ~svc)) & ~clr;
    end

    // Latch, dwell and served-pulse state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            in_pend_q  <= '0;
            out_pend_q <= '0;
            dwell_q    <= '0;
            floor_q    <= '0;
            served_q   <= '0;
        end else begin
            in_pend_q  <= in_pend_d;
            out_pend_q <= out_pend_d;
            dwell_q    <= dwell_d;
            floor_q    <= floor_d;
            served_q   <= clr;
        end
    end

    assign inPend  = in_pend_q;
    assign outPend = out_pend_q;
    assign served  = served_q;
    assign pending = in_pend_q | out_pend_q;

    // Direction hints relative to the current floor; invalid loc gives none.
    always_comb begin
        reqAbove = 1'b0;
        reqBelow = 1'b0;
        reqHere  = 1'b0;
        case (loc)
            3'b001: begin
                reqAbove = pending[2] | pending[3];
                reqHere  = pending[1];
            end
            3'b010: begin
                reqAbove = pending[3];
                reqBelow = pending[1];
                reqHere  = pending[2];
            end
            3'b100: begin
                reqBelow = pending[1] | pending[2];
                reqHere  = pending[3];
            end
            default: begin
                reqAbove = 1'b0;
                reqBelow = 1'b0;
                reqHere  = 1'b0;
            end
        endcase
    end

endmodule
